// File: rtl/msg_rx_pkg.sv
// Shared types, defaults and width helpers for the multi-type serial message receiver.
package msg_rx_pkg;

    typedef enum logic [1:0] {
        StHunt,
        StSync,
        StPayload,
        StCheck
    } rx_state_e;

    // Type 0 occupies the low slice; the MSB byte of each slice is sent first.
    localparam logic [79:0] DefaultSyncWords   = {"FGHIJ", "ABCDE"};
    localparam logic [31:0] DefaultPayloadLens = {16'd16, 16'd8};

    function automatic int unsigned MinBitWidth(input int unsigned value);
        return (value <= 32'd1) ? 32'd1 : 32'($clog2(64'(value) + 64'd1));
    endfunction

    function automatic int unsigned TypeWidth(input int unsigned num_types);
        return (num_types <= 32'd2) ? 32'd1 : 32'($clog2(num_types));
    endfunction

endpackage

// File: rtl/sync_matcher.sv
// Combinational per-type sync byte compare with a lowest-index priority encoder.
module sync_matcher import msg_rx_pkg::*; #(
    parameter int unsigned NUM_TYPES = 2,
    parameter int unsigned SYNC_LEN_BYTE = 5,
    parameter logic [NUM_TYPES*SYNC_LEN_BYTE*8-1:0] SYNC_WORDS = DefaultSyncWords,
    localparam int unsigned IDX_W = MinBitWidth(SYNC_LEN_BYTE),
    localparam int unsigned TYPE_W = TypeWidth(NUM_TYPES)
) (
    input  logic [7:0]           rx_byte,
    input  logic [IDX_W-1:0]     sync_idx,
    input  logic [NUM_TYPES-1:0] active_mask,
    output logic [NUM_TYPES-1:0] match_mask,
    output logic [NUM_TYPES-1:0] restart_mask,
    output logic [TYPE_W-1:0]    match_type
);

    localparam int unsigned WordBits = NUM_TYPES * SYNC_LEN_BYTE * 8;

    function automatic logic [7:0] sync_byte(input int unsigned t, input int unsigned k);
        int unsigned pos;
        pos = t * SYNC_LEN_BYTE + (SYNC_LEN_BYTE - 1 - k);
        return 8'(SYNC_WORDS >> (pos * 8));
    endfunction

    always_comb begin
        match_mask   = '0;
        restart_mask = '0;
        for (int unsigned t = 0; t < NUM_TYPES; t++) begin
            match_mask[t]   = active_mask[t] && (rx_byte == sync_byte(t, 32'(sync_idx)));
            restart_mask[t] = (rx_byte == sync_byte(t, 0));
        end
    end

    // Walk downwards so the lowest set index is the one left standing.
    always_comb begin
        match_type = '0;
        for (int t = int'(NUM_TYPES) - 1; t >= 0; t--) begin
            if (match_mask[t]) begin
                match_type = TYPE_W'(t);
            end
        end
    end

    logic unused_width;
    assign unused_width = (WordBits == 0);

endmodule

// File: rtl/multi_msg_receiver.sv
// Hunts a byte stream for one of several sync words and forwards the tagged payload bytes.
module multi_msg_receiver import msg_rx_pkg::*; #(
    parameter int unsigned NUM_TYPES = 2,
    parameter int unsigned SYNC_LEN_BYTE = 5,
    parameter logic [NUM_TYPES*SYNC_LEN_BYTE*8-1:0] SYNC_WORDS = DefaultSyncWords,
    parameter logic [NUM_TYPES*16-1:0] PAYLOAD_LENS = DefaultPayloadLens,
    parameter bit CHECKSUM_EN = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    localparam int unsigned TYPE_W = TypeWidth(NUM_TYPES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_ready,
    output logic [7:0]        msg_out,
    output logic [TYPE_W-1:0] msg_type,
    output logic              data_valid,
    output logic              msg_start,
    output logic              msg_end,
    output logic              msg_done,
    output logic              checksum_err,
    output logic              msg_abort
);

    localparam int unsigned IDX_W = MinBitWidth(SYNC_LEN_BYTE);
    localparam int unsigned TMO_W = MinBitWidth(TIMEOUT_CYCLES);
    localparam int unsigned SW    = SYNC_LEN_BYTE * 8;

    function automatic logic [15:0] len_of(input int unsigned t);
        return 16'(PAYLOAD_LENS >> (t * 16));
    endfunction

    function automatic bit cfg_ok();
        logic [SW-1:0] wa;
        logic [SW-1:0] wb;
        if (NUM_TYPES < 1 || NUM_TYPES > 8 || SYNC_LEN_BYTE < 1 || SYNC_LEN_BYTE > 16) begin
            return 1'b0;
        end
        for (int unsigned a = 0; a < NUM_TYPES; a++) begin
            if (len_of(a) == 16'd0) begin
                return 1'b0;
            end
            wa = SW'(SYNC_WORDS >> (a * SW));
            for (int unsigned b = a + 1; b < NUM_TYPES; b++) begin
                wb = SW'(SYNC_WORDS >> (b * SW));
                if (wa == wb) begin
                    return 1'b0;
                end
            end
        end
        return 1'b1;
    endfunction

    localparam bit CfgOk = cfg_ok();

    if (!CfgOk) begin : g_bad_cfg
        $error("multi_msg_receiver: duplicate sync word, zero payload length or bad range");
    end

    rx_state_e          state_q, state_d;
    logic [NUM_TYPES-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TYPE_W-1:0]  type_q, type_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [7:0]         acc_q, acc_d;
    logic               first_q, first_d;
    logic [TMO_W-1:0]   idle_q, idle_d;
    logic               done_pend_q, done_pend_d;

    logic [7:0]         msg_out_q, msg_out_d;
    logic [TYPE_W-1:0]  msg_type_q, msg_type_d;
    logic               data_valid_q, data_valid_d;
    logic               msg_start_q, msg_start_d;
    logic               msg_end_q, msg_end_d;
    logic               msg_done_q, msg_done_d;
    logic               checksum_err_q, checksum_err_d;
    logic               msg_abort_q, msg_abort_d;

    logic [IDX_W-1:0]     match_idx;
    logic [NUM_TYPES-1:0] match_active;
    logic [NUM_TYPES-1:0] match_mask;
    logic [NUM_TYPES-1:0] restart_mask;
    logic [TYPE_W-1:0]    match_type;

    // Outside SYNC every type is a candidate against sync byte 0.
    assign match_idx    = (state_q == StSync) ? idx_q : '0;
    assign match_active = (state_q == StSync) ? mask_q : '1;

    sync_matcher #(
        .NUM_TYPES     (NUM_TYPES),
        .SYNC_LEN_BYTE (SYNC_LEN_BYTE),
        .SYNC_WORDS    (SYNC_WORDS)
    ) u_sync_matcher (
        .rx_byte      (rx_data),
        .sync_idx     (match_idx),
        .active_mask  (match_active),
        .match_mask   (match_mask),
        .restart_mask (restart_mask),
        .match_type   (match_type)
    );

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        idx_d          = idx_q;
        type_d         = type_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        first_d        = first_q;
        idle_d         = '0;
        done_pend_d    = 1'b0;
        msg_out_d      = msg_out_q;
        msg_type_d     = msg_type_q;
        data_valid_d   = 1'b0;
        msg_start_d    = 1'b0;
        msg_end_d      = 1'b0;
        msg_done_d     = done_pend_q;
        checksum_err_d = 1'b0;
        msg_abort_d    = 1'b0;

        unique case (state_q)
            StHunt: begin
                if (rx_data_ready && (|match_mask)) begin
                    if (SYNC_LEN_BYTE == 1) begin
                        state_d = StPayload;
                        type_d  = match_type;
                        cnt_d   = len_of(32'(match_type));
                        acc_d   = '0;
                        first_d = 1'b1;
                        mask_d  = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = StSync;
                        mask_d  = match_mask;
                        idx_d   = IDX_W'(1);
                    end
                end
            end
            StSync: begin
                if (rx_data_ready) begin
                    if (|match_mask) begin
                        if (idx_q == IDX_W'(SYNC_LEN_BYTE - 1)) begin
                            state_d = StPayload;
                            type_d  = match_type;
                            cnt_d   = len_of(32'(match_type));
                            acc_d   = '0;
                            first_d = 1'b1;
                            mask_d  = '0;
                            idx_d   = '0;
                        end else begin
                            mask_d = match_mask;
                            idx_d  = idx_q + IDX_W'(1);
                        end
                    end else if (|restart_mask) begin
                        // The breaking byte may itself open a new sync word.
                        mask_d = restart_mask;
                        idx_d  = IDX_W'(1);
                    end else begin
                        state_d = StHunt;
                        mask_d  = '0;
                        idx_d   = '0;
                    end
                end
            end
            StPayload: begin
                if (rx_data_ready) begin
                    msg_out_d    = rx_data;
                    data_valid_d = 1'b1;
                    msg_start_d  = first_q;
                    if (first_q) begin
                        msg_type_d = type_q;
                    end
                    first_d = 1'b0;
                    acc_d   = acc_q + rx_data;
                    cnt_d   = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        msg_end_d = 1'b1;
                        if (CHECKSUM_EN) begin
                            state_d = StCheck;
                        end else begin
                            state_d     = StHunt;
                            done_pend_d = 1'b1;
                        end
                    end
                end
            end
            StCheck: begin
                if (rx_data_ready) begin
                    msg_done_d     = 1'b1;
                    checksum_err_d = (rx_data != acc_q);
                    state_d        = StHunt;
                end
            end
            default: begin
                state_d = StHunt;
            end
        endcase

        if (TIMEOUT_CYCLES != 0 && state_q != StHunt && !rx_data_ready) begin
            if (idle_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d     = StHunt;
                mask_d      = '0;
                idx_d       = '0;
                msg_abort_d = (state_q == StPayload) || (state_q == StCheck);
            end else begin
                idle_d = idle_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StHunt;
            mask_q         <= '0;
            idx_q          <= '0;
            type_q         <= '0;
            cnt_q          <= '0;
            acc_q          <= '0;
            first_q        <= 1'b0;
            idle_q         <= '0;
            done_pend_q    <= 1'b0;
            msg_out_q      <= '0;
            msg_type_q     <= '0;
            data_valid_q   <= 1'b0;
            msg_start_q    <= 1'b0;
            msg_end_q      <= 1'b0;
            msg_done_q     <= 1'b0;
            checksum_err_q <= 1'b0;
            msg_abort_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            idx_q          <= idx_d;
            type_q         <= type_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            first_q        <= first_d;
            idle_q         <= idle_d;
            done_pend_q    <= done_pend_d;
            msg_out_q      <= msg_out_d;
            msg_type_q     <= msg_type_d;
            data_valid_q   <= data_valid_d;
            msg_start_q    <= msg_start_d;
            msg_end_q      <= msg_end_d;
            msg_done_q     <= msg_done_d;
            checksum_err_q <= checksum_err_d;
            msg_abort_q    <= msg_abort_d;
        end
    end

    assign msg_out      = msg_out_q;
    assign msg_type     = msg_type_q;
    assign data_valid   = data_valid_q;
    assign msg_start    = msg_start_q;
    assign msg_end      = msg_end_q;
    assign msg_done     = msg_done_q;
    assign checksum_err = checksum_err_q;
    assign msg_abort    = msg_abort_q;

endmodule

// File: tb/tb_multi_msg_receiver.sv
// Directed bench: one receiver with checksum, one without, fed independent byte streams.
module tb_multi_msg_receiver;

    localparam int unsigned Tmo = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_ready_a, rx_ready_b;

    logic [7:0] msg_out_a, msg_out_b;
    logic [0:0] msg_type_a, msg_type_b;
    logic dv_a, start_a, end_a, done_a, cerr_a, abort_a;
    logic dv_b, start_b, end_b, done_b, cerr_b, abort_b;

    multi_msg_receiver #(
        .NUM_TYPES      (2),
        .SYNC_LEN_BYTE  (5),
        .SYNC_WORDS     ({"FGHIJ", "ABCDE"}),
        .PAYLOAD_LENS   ({16'd16, 16'd8}),
        .CHECKSUM_EN    (1'b1),
        .TIMEOUT_CYCLES (Tmo)
    ) u_dut_ck (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data_a),
        .rx_data_ready (rx_ready_a),
        .msg_out       (msg_out_a),
        .msg_type      (msg_type_a),
        .data_valid    (dv_a),
        .msg_start     (start_a),
        .msg_end       (end_a),
        .msg_done      (done_a),
        .checksum_err  (cerr_a),
        .msg_abort     (abort_a)
    );

    multi_msg_receiver #(
        .NUM_TYPES      (2),
        .SYNC_LEN_BYTE  (5),
        .SYNC_WORDS     ({"FGHIJ", "ABCDE"}),
        .PAYLOAD_LENS   ({16'd16, 16'd8}),
        .CHECKSUM_EN    (1'b0),
        .TIMEOUT_CYCLES (Tmo)
    ) u_dut_nc (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data_b),
        .rx_data_ready (rx_ready_b),
        .msg_out       (msg_out_b),
        .msg_type      (msg_type_b),
        .data_valid    (dv_b),
        .msg_start     (start_b),
        .msg_end       (end_b),
        .msg_done      (done_b),
        .checksum_err  (cerr_b),
        .msg_abort     (abort_b)
    );

    // Event monitors, sampled on the falling edge away from register updates.
    int         a_dv = 0, a_done = 0, a_abort = 0;
    logic [7:0] a_start_byte = 8'h00, a_end_byte = 8'h00;
    logic       a_start_type = 1'b0, a_done_type = 1'b0, a_last_cerr = 1'b0;
    logic [7:0] a_bytes[$];

    int          cyc = 0, b_dv = 0, b_done = 0, b_start = 0, b_cerr = 0;
    int          b_end_cyc = 0, b_done_cyc = 0;
    logic [31:0] b_sum = 32'd0;
    logic [1:0]  b_types = 2'b00;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (dv_a) begin
            a_dv <= a_dv + 1;
            a_bytes.push_back(msg_out_a);
            if (start_a) begin
                a_start_byte <= msg_out_a;
                a_start_type <= msg_type_a;
            end
            if (end_a) a_end_byte <= msg_out_a;
        end
        if (done_a) begin
            a_done      <= a_done + 1;
            a_last_cerr <= cerr_a;
            a_done_type <= msg_type_a;
        end
        if (abort_a) a_abort <= a_abort + 1;
        if (dv_b) begin
            b_dv  <= b_dv + 1;
            b_sum <= b_sum + 32'(msg_out_b);
            if (start_b) begin
                b_start <= b_start + 1;
                b_types <= {b_types[0], msg_type_b};
            end
            if (end_b) b_end_cyc <= cyc;
        end
        if (done_b) begin
            b_done     <= b_done + 1;
            b_done_cyc <= cyc;
            if (cerr_b) b_cerr <= b_cerr + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic send_a(input logic [7:0] b);
        rx_data_a  = b;
        rx_ready_a = 1'b1;
        @(posedge clk);
        #1;
        rx_ready_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        rx_data_b  = b;
        rx_ready_b = 1'b1;
        @(posedge clk);
        #1;
        rx_ready_b = 1'b0;
    endtask

    task automatic send_str_a(input string s);
        for (int i = 0; i < s.len(); i++) send_a(s[i]);
    endtask

    task automatic send_str_b(input string s);
        for (int i = 0; i < s.len(); i++) send_b(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // "ABCDE", 0x01..0x08, checksum 0x24.
    task automatic send_good_a();
        send_str_a("ABCDE");
        for (int i = 1; i <= 8; i++) send_a(8'(i));
        send_a(8'h24);
    endtask

    initial begin
        int base_dv, base_done, base_abort, qi, n;
        bit found;

        reset      = 1'b0;
        rx_data_a  = 8'h00;
        rx_data_b  = 8'h00;
        rx_ready_a = 1'b0;
        rx_ready_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs_a", {msg_out_a, msg_type_a, dv_a, start_a, end_a, done_a, cerr_a, abort_a},
              32'd0);
        check("rst_outs_b", {msg_out_b, msg_type_b, dv_b, start_b, end_b, done_b, cerr_b, abort_b},
              32'd0);
        reset = 1'b1;
        idle(2);

        // Type 0 with good checksum, plus output latency checks.
        base_dv = a_dv; base_done = a_done; base_abort = a_abort; qi = a_bytes.size();
        send_str_a("ABCDE");
        for (int i = 1; i <= 8; i++) begin
            send_a(8'(i));
            if (i == 1) check("t1_first_latency", {dv_a, start_a, msg_out_a}, {1'b1, 1'b1, 8'h01});
            if (i == 8) check("t1_last_latency", {dv_a, end_a, msg_out_a}, {1'b1, 1'b1, 8'h08});
        end
        send_a(8'h24);
        check("t1_done_latency", {done_a, cerr_a}, 2'b10);
        idle(3);
        check("t1_dv_count", a_dv - base_dv, 8);
        for (int i = 0; i < 8; i++) check("t1_byte", a_bytes[qi + i], 8'(i + 1));
        check("t1_start_byte", a_start_byte, 8'h01);
        check("t1_end_byte", a_end_byte, 8'h08);
        check("t1_type", {a_start_type, a_done_type}, 2'b00);
        check("t1_done_count", a_done - base_done, 1);
        check("t1_cerr", a_last_cerr, 1'b0);
        check("t1_abort_count", a_abort - base_abort, 0);

        // Type 1, checksum mismatch (sum 0xF0 vs 0x00).
        base_dv = a_dv; base_done = a_done;
        send_str_a("FGHIJ");
        repeat (16) send_a(8'hFF);
        send_a(8'h00);
        idle(3);
        check("t2_dv_count", a_dv - base_dv, 16);
        check("t2_type", {a_start_type, a_done_type}, 2'b11);
        check("t2_done_count", a_done - base_done, 1);
        check("t2_cerr", a_last_cerr, 1'b1);

        // Resync on a partial match: "ABABCDE".
        base_dv = a_dv; base_done = a_done;
        send_str_a("ABABCDE");
        for (int i = 0; i < 8; i++) send_a(8'(8'h10 + i));
        send_a(8'h9C);
        idle(3);
        check("t3_dv_count", a_dv - base_dv, 8);
        check("t3_start_byte", a_start_byte, 8'h10);
        check("t3_type", a_start_type, 1'b0);
        check("t3_done_count", a_done - base_done, 1);
        check("t3_cerr", a_last_cerr, 1'b0);

        // Payload timeout: abort on the Tmo-th idle cycle, no done.
        base_dv = a_dv; base_done = a_done; base_abort = a_abort;
        send_str_a("ABCDE");
        send_a(8'hAA); send_a(8'hBB); send_a(8'hCC);
        n = 0; found = 1'b0;
        while (!found && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (abort_a) found = 1'b1;
        end
        check("t4_abort_cycle", n, Tmo);
        idle(5);
        check("t4_abort_count", a_abort - base_abort, 1);
        check("t4_dv_count", a_dv - base_dv, 3);
        check("t4_no_done", a_done - base_done, 0);

        // Sync timeout is silent and drops the partial match.
        base_dv = a_dv; base_done = a_done; base_abort = a_abort;
        send_str_a("AB");
        idle(Tmo + 10);
        send_str_a("CDE");
        for (int i = 1; i <= 8; i++) send_a(8'(i));
        send_a(8'h24);
        idle(3);
        check("t4_sync_tmo_silent", a_abort - base_abort, 0);
        check("t4_sync_tmo_dropped", {16'(a_dv - base_dv), 16'(a_done - base_done)}, 32'd0);

        base_done = a_done;
        send_good_a();
        idle(3);
        check("t4_recover_done", a_done - base_done, 1);
        check("t4_recover_cerr", a_last_cerr, 1'b0);

        // Back-to-back messages without checksum.
        send_str_b("ABCDE");
        for (int i = 1; i <= 8; i++) send_b(8'(i));
        send_str_b("FGHIJ");
        for (int i = 0; i < 16; i++) send_b(8'(8'h30 + i));
        idle(4);
        check("t5_dv_count", b_dv, 24);
        check("t5_done_count", b_done, 2);
        check("t5_start_count", b_start, 2);
        check("t5_types", b_types, 2'b01);
        check("t5_byte_sum", b_sum, 32'd924);
        check("t5_done_after_end", b_done_cyc - b_end_cyc, 1);
        check("t5_cerr_count", b_cerr, 0);

        // Reset in the middle of a type-1 payload.
        send_str_a("FGHIJ");
        send_a(8'h5A); send_a(8'h5B); send_a(8'h5C);
        check("t6_pre_reset", {dv_a, msg_type_a, msg_out_a}, {1'b1, 1'b1, 8'h5C});
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_clear",
              {msg_out_a, msg_type_a, dv_a, start_a, end_a, done_a, cerr_a, abort_a}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        base_dv = a_dv; base_done = a_done; base_abort = a_abort;
        idle(Tmo + 10);
        check("t6_quiet_after_reset",
              {8'(a_dv - base_dv), 8'(a_done - base_done), 8'(a_abort - base_abort)}, 32'd0);
        base_dv = a_dv; base_done = a_done;
        send_good_a();
        idle(3);
        check("t6_recover_dv", a_dv - base_dv, 8);
        check("t6_recover_done", {8'(a_done - base_done), 7'd0, a_last_cerr}, {8'd1, 8'd0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
